// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_arb_pkg;

  typedef logic [3:0] reg_addr_t;

  localparam reg_addr_t   PC_ADDR    = 4'd15;
  localparam int unsigned ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    FORCE
  } arb_state_e;

  typedef struct packed {
    reg_addr_t             a;
    logic [ARB_DATA_W-1:0] wd;
  } mc_entry_t;

endpackage

// File: rtl/rf_arb_fifo.sv
// Count-based FIFO holding MCycle results; push and pop may share a cycle.
module rf_arb_fifo
  import rf_arb_pkg::*;
#(
  parameter int unsigned QDEPTH  = 2,
  parameter type         entry_t = mc_entry_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  entry_t                     din,
  input  logic                       pop,
  output entry_t                     dout,
  output logic [$clog2(QDEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  entry_t          mem_q [QDEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  // Pointer and occupancy update; depth is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single RF write port between writeback and the MCycle unit,
// queues MCycle results and tracks pending destinations in a busy scoreboard.
// Optional macro ARB_WAW_CHECK_EN adds the sticky WAW_Err output.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned QDEPTH       = 2,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned DATA_W       = 32
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              WB_WE,
  input  logic [3:0]        WB_A,
  input  logic [DATA_W-1:0] WB_WD,
  input  logic              MC_Valid,
  input  logic [3:0]        MC_A,
  input  logic [DATA_W-1:0] MC_WD,
  output logic              MC_Ready,
  input  logic              Issue_Valid,
  input  logic [3:0]        Issue_A,
  input  logic [3:0]        Chk_A1,
  input  logic [3:0]        Chk_A2,
  output logic              Hazard,
  output logic [15:0]       Busy,
  output logic              Stall_WB,
  output logic              WE3,
  output logic [3:0]        A3,
  output logic [DATA_W-1:0] WD3
`ifdef ARB_WAW_CHECK_EN
  ,
  output logic              WAW_Err
`endif
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    reg_addr_t         a;
    logic [DATA_W-1:0] wd;
  } entry_t;

  entry_t            fifo_din, head;
  logic [CW-1:0]     count, count_after;
  logic              push, pop, not_empty, full, wb_grant;
  logic [SW-1:0]     starve_nxt;

  arb_state_e        state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              force_q, force_d;
  logic              stall_q, stall_d;
  logic [15:0]       busy_q, busy_d;
  logic              we3_q, we3_d;
  logic [3:0]        a3_q, a3_d;
  logic [DATA_W-1:0] wd3_q, wd3_d;

  rf_arb_fifo #(
    .QDEPTH  (QDEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESETn),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (head),
    .count (count)
  );

  // Queue handshake and grant: writeback wins unless a forced drain is due.
  always_comb begin
    fifo_din    = '{a: MC_A, wd: MC_WD};
    MC_Ready    = count < CW'(QDEPTH);
    full        = count == CW'(QDEPTH);
    not_empty   = count != '0;
    push        = MC_Valid & MC_Ready;
    wb_grant    = WB_WE & ~force_q;
    pop         = not_empty & (~WB_WE | force_q);
    count_after = count + CW'(push) - CW'(pop);
  end

  // Scoreboard: an issue setting a bit overrides a drain clearing it.
  always_comb begin
    busy_d = busy_q;
    if (pop && head.a != PC_ADDR)             busy_d[head.a]  = 1'b0;
    if (Issue_Valid && Issue_A != PC_ADDR)    busy_d[Issue_A] = 1'b1;
  end

  // RF write port; a popped PC-targeted entry is discarded without a write.
  always_comb begin
    we3_d = 1'b0;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    if (wb_grant) begin
      we3_d = 1'b1;
      a3_d  = WB_A;
      wd3_d = WB_WD;
    end else if (pop && head.a != PC_ADDR) begin
      we3_d = 1'b1;
      a3_d  = head.a;
      wd3_d = head.wd;
    end
  end

  // Starvation FSM: FORCE raises Stall_WB for one cycle, the following cycle drains.
  always_comb begin
    starve_nxt = starve_q;
    if (full && WB_WE && starve_q < SW'(STARVE_LIMIT)) starve_nxt = starve_q + SW'(1);
    starve_d = pop ? '0 : starve_nxt;
    state_d  = state_q;
    force_d  = (state_q == FORCE);
    case (state_q)
      IDLE:  if (push) state_d = PEND;
      PEND: begin
        if (count_after == '0) begin
          state_d = IDLE;
        end else if (!pop && starve_nxt == SW'(STARVE_LIMIT)) begin
          state_d  = FORCE;
          starve_d = '0;
        end
      end
      FORCE:   state_d = (count_after == '0) ? IDLE : PEND;
      default: state_d = IDLE;
    endcase
    stall_d = (state_d == FORCE);
  end

  // Arbiter state registers.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q  <= IDLE;
      starve_q <= '0;
      force_q  <= 1'b0;
      stall_q  <= 1'b0;
      busy_q   <= '0;
      we3_q    <= 1'b0;
      a3_q     <= '0;
      wd3_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      force_q  <= force_d;
      stall_q  <= stall_d;
      busy_q   <= busy_d;
      we3_q    <= we3_d;
      a3_q     <= a3_d;
      wd3_q    <= wd3_d;
    end
  end

  assign Hazard   = busy_q[Chk_A1] | busy_q[Chk_A2];
  assign Busy     = busy_q;
  assign Stall_WB = stall_q;
  assign WE3      = we3_q;
  assign A3       = a3_q;
  assign WD3      = wd3_q;

`ifdef ARB_WAW_CHECK_EN
  logic waw_q, waw_d;

  // Sticky flag for a writeback racing a pending MCycle result.
  always_comb begin
    waw_d = waw_q | (WB_WE & busy_q[WB_A]);
  end

  // WAW flag register.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) waw_q <= 1'b0;
    else         waw_q <= waw_d;
  end

  assign WAW_Err = waw_q;
`endif

endmodule
